// File: rtl/univ_shift_reg.sv
// Universal shift register: W-bit lanes, left/right shift, parallel load,
// hold, and a frame counter that pulses once per N/W counted shifts.
module univ_shift_reg #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 1,
    localparam int unsigned L  = N / W,
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    ctrl,
    input  logic [W-1:0]  s_in_r,
    input  logic [W-1:0]  s_in_l,
    input  logic [N-1:0]  d,
    output logic [N-1:0]  q,
    output logic [W-1:0]  s_out_r,
    output logic [W-1:0]  s_out_l,
    output logic [CW-1:0] cnt,
    output logic          frame_done
);

    localparam logic [1:0] CTRL_HOLD = 2'b00;
    localparam logic [1:0] CTRL_SHR  = 2'b01;
    localparam logic [1:0] CTRL_SHL  = 2'b10;
    localparam logic [1:0] CTRL_LOAD = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(L - 1);

    // Reject register widths that are not a whole number of lanes.
    if (W == 0 || N < W || (N % W) != 0) begin : g_bad_params
        $error("univ_shift_reg: N (%0d) must be a non-zero multiple of W (%0d)", N, W);
    end

    logic [N-1:0]  shr_val;
    logic [N-1:0]  shl_val;
    logic [N-1:0]  q_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          frame_done_nxt;
    logic          is_shift;
    logic          at_last;

    // Shift results; a single-lane register simply takes the incoming lane.
    if (N == W) begin : g_single_lane
        assign shr_val = s_in_r;
        assign shl_val = s_in_l;
    end else begin : g_multi_lane
        assign shr_val = {s_in_r, q[N-1:W]};
        assign shl_val = {q[N-W-1:0], s_in_l};
    end

    // Lanes leaving the register are slices of the registered contents.
    assign s_out_r = q[W-1:0];
    assign s_out_l = q[N-1:N-W];

    assign is_shift = (ctrl == CTRL_SHR) || (ctrl == CTRL_SHL);
    assign at_last  = (cnt == CNT_LAST);

    // Next-state for data, frame counter and frame pulse.
    always_comb begin
        q_nxt          = q;
        cnt_nxt        = cnt;
        frame_done_nxt = 1'b0;
        case (ctrl)
            CTRL_HOLD: q_nxt = q;
            CTRL_SHR:  q_nxt = shr_val;
            CTRL_SHL:  q_nxt = shl_val;
            CTRL_LOAD: begin
                q_nxt   = d;
                cnt_nxt = '0;
            end
            default:   q_nxt = q;
        endcase
        // Both directions count toward the same frame.
        if (is_shift) begin
            if (at_last) begin
                cnt_nxt        = '0;
                frame_done_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q          <= '0;
            cnt        <= '0;
            frame_done <= 1'b0;
        end else begin
            q          <= q_nxt;
            cnt        <= cnt_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg with a scoreboard of expected states.
module tb_univ_shift_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: N=8, W=1
    logic       reset_a;
    logic [1:0] ctrl_a;
    logic       sir_a, sil_a;
    logic [7:0] d_a, q_a;
    logic       sor_a, sol_a;
    logic [2:0] cnt_a;
    logic       fd_a;

    // Instance B: N=8, W=2
    logic       reset_b;
    logic [1:0] ctrl_b;
    logic [1:0] sir_b, sil_b;
    logic [7:0] d_b, q_b;
    logic [1:0] sor_b, sol_b;
    logic [1:0] cnt_b;
    logic       fd_b;

    univ_shift_reg #(.N(8), .W(1)) dut_a (
        .clk(clk), .reset(reset_a), .ctrl(ctrl_a), .s_in_r(sir_a), .s_in_l(sil_a),
        .d(d_a), .q(q_a), .s_out_r(sor_a), .s_out_l(sol_a), .cnt(cnt_a),
        .frame_done(fd_a)
    );

    univ_shift_reg #(.N(8), .W(2)) dut_b (
        .clk(clk), .reset(reset_b), .ctrl(ctrl_b), .s_in_r(sir_b), .s_in_l(sil_b),
        .d(d_b), .q(q_b), .s_out_r(sor_b), .s_out_l(sol_b), .cnt(cnt_b),
        .frame_done(fd_b)
    );

    typedef struct {
        logic [7:0] q;
        int         cnt;
        logic       fd;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    logic [7:0] mq_a, mq_b;
    int         mc_a, mc_b;
    logic       mf_a, mf_b;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference for one clock of an 8-bit register with w-bit lanes.
    task automatic model(input int w, input logic [1:0] c, input logic [7:0] sir,
                         input logic [7:0] sil, input logic [7:0] d,
                         inout logic [7:0] q, inout int cnt, output logic fd);
        int         l = 8 / w;
        logic [7:0] m = 8'((1 << w) - 1);
        fd = 1'b0;
        case (c)
            2'b01: q = (q >> w) | ((sir & m) << (8 - w));
            2'b10: q = (q << w) | (sil & m);
            2'b11: begin q = d; cnt = 0; end
            default: ;
        endcase
        if (c == 2'b01 || c == 2'b10) begin
            if (cnt == l - 1) begin
                cnt = 0;
                fd  = 1'b1;
            end else begin
                cnt++;
            end
        end
    endtask

    task automatic step_a(input logic [1:0] c, input logic sir, input logic sil,
                          input logic [7:0] d);
        exp_t e;
        ctrl_a = c; sir_a = sir; sil_a = sil; d_a = d;
        model(1, c, {7'b0, sir}, {7'b0, sil}, d, mq_a, mc_a, mf_a);
        e.q = mq_a; e.cnt = mc_a; e.fd = mf_a;
        sb_a.push_back(e);
        @(posedge clk);
        #1;
        ctrl_a = 2'b00;
        if (sb_a.size() == 0) begin
            chk("a_scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_a.pop_front();
            chk("a_q",          32'(q_a),   32'(e.q));
            chk("a_cnt",        32'(cnt_a), 32'(e.cnt));
            chk("a_frame_done", 32'(fd_a),  32'(e.fd));
            chk("a_s_out_r",    32'(sor_a), 32'(e.q[0]));
            chk("a_s_out_l",    32'(sol_a), 32'(e.q[7]));
        end
    endtask

    task automatic step_b(input logic [1:0] c, input logic [1:0] sir,
                          input logic [1:0] sil, input logic [7:0] d);
        exp_t e;
        ctrl_b = c; sir_b = sir; sil_b = sil; d_b = d;
        model(2, c, {6'b0, sir}, {6'b0, sil}, d, mq_b, mc_b, mf_b);
        e.q = mq_b; e.cnt = mc_b; e.fd = mf_b;
        sb_b.push_back(e);
        @(posedge clk);
        #1;
        ctrl_b = 2'b00;
        if (sb_b.size() == 0) begin
            chk("b_scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_b.pop_front();
            chk("b_q",          32'(q_b),   32'(e.q));
            chk("b_cnt",        32'(cnt_b), 32'(e.cnt));
            chk("b_frame_done", 32'(fd_b),  32'(e.fd));
            chk("b_s_out_r",    32'(sor_b), 32'(e.q[1:0]));
            chk("b_s_out_l",    32'(sol_b), 32'(e.q[7:6]));
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] t2_seq;
        logic [7:0] t3_seq;
        int         pulses;

        t2_seq = 8'b1010_0101;   // s_out_r before shift i is t2_seq[i]
        t3_seq = 8'b11_10_01_00; // s_out_l before shift i is t3_seq[2i+:2]

        // 1. Reset and hold
        reset_a = 1'b0; ctrl_a = 2'b11; d_a = 8'hFF; sir_a = 1'b0; sil_a = 1'b0;
        reset_b = 1'b0; ctrl_b = 2'b00; d_b = 8'h00; sir_b = 2'b00; sil_b = 2'b00;
        mq_a = 8'h00; mc_a = 0; mf_a = 1'b0;
        mq_b = 8'h00; mc_b = 0; mf_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_reset_q",   32'(q_a),   32'h00);
        chk("t1_reset_cnt", 32'(cnt_a), 32'd0);
        chk("t1_reset_fd",  32'(fd_a),  32'd0);
        chk("t1_reset_q_b", 32'(q_b),   32'h00);
        ctrl_a  = 2'b00;
        reset_a = 1'b1;
        reset_b = 1'b1;
        step_a(2'b00, 1'b0, 1'b0, 8'hFF);
        chk("t1_hold_q", 32'(q_a), 32'h00);

        // 2. Load then right shift
        step_a(2'b11, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            chk("t2_s_out_r", 32'(sor_a), 32'(t2_seq[i]));
            step_a(2'b01, 1'b0, 1'b0, 8'h00);
            if (i < 7) chk("t2_cnt", 32'(cnt_a), 32'(i + 1));
        end
        chk("t2_final_q",  32'(q_a),   32'h00);
        chk("t2_wrap_cnt", 32'(cnt_a), 32'd0);
        chk("t2_fd_pulse", 32'(fd_a),  32'd1);
        step_a(2'b00, 1'b0, 1'b0, 8'h00);
        chk("t2_fd_drop",  32'(fd_a),  32'd0);

        // 3. Left shift with 2-bit lanes
        step_b(2'b11, 2'b00, 2'b00, 8'h1B);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_s_out_l", 32'(sol_b), 32'(t3_seq[2*i +: 2]));
            step_b(2'b10, 2'b00, 2'b11, 8'h00);
            pulses += int'(fd_b);
        end
        chk("t3_final_q", 32'(q_b), 32'hFF);
        step_b(2'b00, 2'b00, 2'b00, 8'h00);
        pulses += int'(fd_b);
        chk("t3_fd_count", 32'(pulses), 32'd1);

        // 4. Mixed direction with holds
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step_a(2'b01, 1'($urandom_range(1, 0)), 1'b0, 8'h00);
            pulses += int'(fd_a);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(2'b00, 1'b0, 1'b0, 8'h00);
            chk("t4_hold_cnt", 32'(cnt_a), 32'd3);
            pulses += int'(fd_a);
        end
        for (int i = 0; i < 5; i++) begin
            step_a(2'b10, 1'b0, 1'($urandom_range(1, 0)), 8'h00);
            pulses += int'(fd_a);
        end
        chk("t4_fd_after_8th", 32'(fd_a), 32'd1);
        step_a(2'b00, 1'b0, 1'b0, 8'h00);
        pulses += int'(fd_a);
        chk("t4_fd_count", 32'(pulses), 32'd1);

        // 5. Load mid-frame
        for (int i = 0; i < 5; i++) begin
            step_a(2'b01, 1'($urandom_range(1, 0)), 1'b0, 8'h00);
        end
        step_a(2'b11, 1'b0, 1'b0, 8'h3C);
        chk("t5_load_q",   32'(q_a),   32'h3C);
        chk("t5_load_cnt", 32'(cnt_a), 32'd0);
        chk("t5_load_fd",  32'(fd_a),  32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step_a((i % 2 == 0) ? 2'b01 : 2'b10, 1'($urandom_range(1, 0)),
                   1'($urandom_range(1, 0)), 8'h00);
            pulses += int'(fd_a);
        end
        step_a(2'b00, 1'b0, 1'b0, 8'h00);
        pulses += int'(fd_a);
        chk("t5_fd_count", 32'(pulses), 32'd1);

        // 6. Asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) begin
            step_a(2'b01, 1'b1, 1'b0, 8'h00);
        end
        chk("t6_pre_cnt", 32'(cnt_a), 32'd6);
        reset_a = 1'b0;
        #2;
        chk("t6_async_q",   32'(q_a),   32'h00);
        chk("t6_async_cnt", 32'(cnt_a), 32'd0);
        chk("t6_async_fd",  32'(fd_a),  32'd0);
        mq_a = 8'h00; mc_a = 0; mf_a = 1'b0;
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step_a(2'b00, 1'b0, 1'b0, 8'h00);
            pulses += int'(fd_a);
        end
        for (int i = 0; i < 2; i++) begin
            step_a(2'b01, 1'b1, 1'b0, 8'h00);
            pulses += int'(fd_a);
        end
        chk("t6_no_fd_after_release", 32'(pulses), 32'd0);
        chk("t6_fresh_cnt",           32'(cnt_a),  32'd2);
        for (int i = 0; i < 6; i++) begin
            step_a(2'b10, 1'b0, 1'b1, 8'h00);
            pulses += int'(fd_a);
        end
        chk("t6_new_frame_fd", 32'(pulses), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
